// File: rtl/jtdd_pkg.sv
// Shared definitions for the JTDD interrupt controller: register map,
// per-channel command struct and the CPU read padding helper.
package jtdd_pkg;

    // CPU register map
    localparam logic [1:0] IRQ_MASK  = 2'd0;
    localparam logic [1:0] IRQ_PEND  = 2'd1;
    localparam logic [1:0] IRQ_POL   = 2'd2;
    localparam logic [1:0] IRQ_FORCE = 2'd3;

    // Per-channel command decoded from CPU writes and acknowledge strobes
    typedef struct packed {
        logic set;   // force write: set pending
        logic clr;   // acknowledge strobe or write-1 to pending
    } irq_req_t;

    // Bits at or above the channel count read back as 1
    function automatic logic [7:0] rd_pad(input logic [7:0] val, input int ch);
        logic [7:0] r;
        r = val;
        for (int i = 0; i < 8; i++)
            if (i >= ch) r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/jtdd_irqctl_ch.sv
// One interrupt channel: source sampling on cen, edge detection in the
// programmed direction and the pending latch (or level follower).
module jtdd_irqctl_ch
    import jtdd_pkg::*;
#(
    parameter bit LEVEL = 1'b0
)(
    input  logic     clk,
    input  logic     rst,
    input  logic     cen,
    input  logic     sig,
    input  logic     pol,
    input  irq_req_t req,
    output logic     pend
);

    logic sig_l;
    logic armed;
    logic edge_det;

    // The raw previous sample is kept; polarity only picks which transition
    // counts, so flipping polarity on a stable source cannot fake an edge.
    always_comb begin
        edge_det = armed && (pol ? (sig_l && !sig) : (!sig_l && sig));
    end

    // Sample the source on cen; the first cen after reset only arms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_l <= 1'b0;
            armed <= 1'b0;
        end else if (cen) begin
            sig_l <= sig;
            armed <= 1'b1;
        end
    end

    // Pending latch: set beats clear; level channels track the active level
    // every cen and a force only holds until the next cen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (LEVEL) begin
            if (req.set)  pend <= 1'b1;
            else if (cen) pend <= sig ^ pol;
        end else begin
            if ((cen && edge_det) || req.set) pend <= 1'b1;
            else if (req.clr)                 pend <= 1'b0;
        end
    end

endmodule

// File: rtl/jtdd_irqctl.sv
// JTDD interrupt controller: CPU register file (mask, polarity, pending,
// force), read mux and one edge/level channel per interrupt source.
module jtdd_irqctl
    import jtdd_pkg::*;
#(
    parameter int          CH       = 3,
    parameter logic [CH-1:0] POL_RST  = '0,
    parameter logic [CH-1:0] MASK_RST = '1,
    parameter logic [CH-1:0] LEVEL    = '0
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [CH-1:0] sigin,
    input  logic [CH-1:0] clr,
    input  logic          cs,
    input  logic          wr,
    input  logic [1:0]    addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CH-1:0] pend,
    output logic [CH-1:0] irq_n
);

    logic [CH-1:0]           mask;
    logic [CH-1:0]           pol;
    logic                    wr_en;
    irq_req_t [CH-1:0]       req;
    logic [7:0]              rd;
    logic                    unused_din;

    assign wr_en = cs & wr;

    // Write-data bits above the channel count are don't-care
    assign unused_din = ^din;

    // Mask and polarity registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= MASK_RST;
            pol  <= POL_RST;
        end else if (wr_en) begin
            if (addr == IRQ_MASK) mask <= din[CH-1:0];
            if (addr == IRQ_POL)  pol  <= din[CH-1:0];
        end
    end

    // Per-channel set/clear commands from force writes, pending writes and acks
    always_comb begin
        req = '0;
        for (int i = 0; i < CH; i++) begin
            req[i].set = wr_en && (addr == IRQ_FORCE) && din[i];
            req[i].clr = clr[i] || (wr_en && (addr == IRQ_PEND) && din[i]);
        end
    end

    generate
        for (genvar g = 0; g < CH; g++) begin : g_ch
            jtdd_irqctl_ch #(.LEVEL(LEVEL[g])) u_ch (
                .clk  (clk),
                .rst  (rst),
                .cen  (cen),
                .sig  (sigin[g]),
                .pol  (pol[g]),
                .req  (req[g]),
                .pend (pend[g])
            );
        end
    endgenerate

    // Requests straight from registers so unmasking acts immediately
    assign irq_n = ~(pend & mask);

    // CPU read mux; force register reads as zero
    always_comb begin
        rd = '0;
        case (addr)
            IRQ_MASK: rd[CH-1:0] = mask;
            IRQ_PEND: rd[CH-1:0] = pend;
            IRQ_POL:  rd[CH-1:0] = pol;
            default:  rd = '0;
        endcase
        dout = rd_pad(rd, CH);
    end

endmodule

// File: tb/tb_jtdd_irqctl.sv
// Directed bench for jtdd_irqctl: an edge-mode instance and a LEVEL=001
// instance share stimulus; a behavioural model checks every cycle and
// literal expectations pin the scenarios.
module tb_jtdd_irqctl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen = 1'b0;
    logic [2:0] sigin = '0;
    logic [2:0] clr = '0;
    logic       cs = 1'b0;
    logic       wr = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] din = '0;

    logic [7:0] dout0, dout1;
    logic [2:0] pend0, pend1, irqn0, irqn1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit run = 1'b0;

    jtdd_irqctl #(.CH(3)) u_dut (
        .clk(clk), .rst(rst), .cen(cen), .sigin(sigin), .clr(clr),
        .cs(cs), .wr(wr), .addr(addr), .din(din),
        .dout(dout0), .pend(pend0), .irq_n(irqn0)
    );

    jtdd_irqctl #(.CH(3), .LEVEL(3'b001)) u_lvl (
        .clk(clk), .rst(rst), .cen(cen), .sigin(sigin), .clr(clr),
        .cs(cs), .wr(wr), .addr(addr), .din(din),
        .dout(dout1), .pend(pend1), .irq_n(irqn1)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [2:0] m_pend [2];
    logic [2:0] m_mask [2];
    logic [2:0] m_pol  [2];
    logic [2:0] m_prev [2];
    bit         m_arm  [2];

    function automatic logic [2:0] lvl(input int k);
        return (k == 1) ? 3'b001 : 3'b000;
    endfunction

    function automatic logic [2:0] nxt_pend(input int k);
        logic [2:0] r, lv;
        bit frc, ack, cur, prv, rose, fell, hit;
        r  = m_pend[k];
        lv = lvl(k);
        for (int i = 0; i < 3; i++) begin
            frc  = cs && wr && (addr == 2'd3) && din[i];
            ack  = clr[i] || (cs && wr && (addr == 2'd1) && din[i]);
            cur  = sigin[i];
            prv  = m_prev[k][i];
            rose = !prv && cur;
            fell = prv && !cur;
            hit  = cen && m_arm[k] && (m_pol[k][i] ? fell : rose);
            if (lv[i]) begin
                if (frc)      r[i] = 1'b1;
                else if (cen) r[i] = cur ^ m_pol[k][i];
            end else begin
                if (frc || hit) r[i] = 1'b1;
                else if (ack)   r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_dout(input int k);
        case (addr)
            2'd0:    return {5'h1F, m_mask[k]};
            2'd1:    return {5'h1F, m_pend[k]};
            2'd2:    return {5'h1F, m_pol[k]};
            default: return 8'hF8;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k] <= 3'b000;
                m_mask[k] <= 3'b111;
                m_pol[k]  <= 3'b000;
                m_prev[k] <= 3'b000;
                m_arm[k]  <= 1'b0;
            end else begin
                m_pend[k] <= nxt_pend(k);
                if (cs && wr && addr == 2'd0) m_mask[k] <= din[2:0];
                if (cs && wr && addr == 2'd2) m_pol[k]  <= din[2:0];
                if (cen) begin
                    m_prev[k] <= sigin;
                    m_arm[k]  <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (run) begin
            chk("m_pend0", {5'd0, pend0}, {5'd0, m_pend[0]});
            chk("m_irqn0", {5'd0, irqn0}, {5'd0, ~(m_pend[0] & m_mask[0])});
            chk("m_dout0", dout0, exp_dout(0));
            chk("m_pend1", {5'd0, pend1}, {5'd0, m_pend[1]});
            chk("m_irqn1", {5'd0, irqn1}, {5'd0, ~(m_pend[1] & m_mask[1])});
            chk("m_dout1", dout1, exp_dout(1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cen = (cyc % 4 == 0);
        clr = '0;
        cs  = 1'b0;
        wr  = 1'b0;
    endtask

    task automatic to_cen();
        int n;
        n = 0;
        while (!cen && n < 8) begin
            tick();
            n++;
        end
        if (!cen) begin
            miscompares++;
            $display("FAIL to_cen: got no cen within 8 clk");
        end
    endtask

    task automatic wreg(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; din = d;
        tick();
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(name, dout0, exp);
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1 rst = 1'b1;
        run = 1'b1;
        tick(); tick();
        // reset state
        chk("rst_pend", {5'd0, pend0}, 8'h00);
        chk("rst_irqn", {5'd0, irqn0}, 8'h07);
        rd_chk("rst_mask_rd", 2'd0, 8'hFF);
        rd_chk("rst_pol_rd",  2'd2, 8'hF8);
        rst = 1'b0;

        // rising edge on ch2, then ack
        to_cen(); tick();
        sigin[2] = 1'b1;
        to_cen(); tick();
        chk("c2_pend", {5'd0, pend0}, 8'h04);
        chk("c2_irqn", {5'd0, irqn0}, 8'h03);
        clr[2] = 1'b1;
        tick();
        chk("c2_clr_irqn", {5'd0, irqn0}, 8'h07);

        // masked channel still latches; unmask drives irq immediately
        wreg(2'd0, 8'h01);
        sigin[1] = 1'b1;
        to_cen(); tick();
        chk("msk_pend", {5'd0, pend0}, 8'h02);
        chk("msk_irqn", {5'd0, irqn0}, 8'h07);
        wreg(2'd0, 8'h03);
        chk("unmsk_irqn", {5'd0, irqn0}, 8'h05);
        rd_chk("mask_rd", 2'd0, 8'hFB);
        wreg(2'd1, 8'h02);
        wreg(2'd0, 8'hFF);
        rd_chk("mask_wide_rd", 2'd0, 8'hFF);

        // falling polarity on ch1
        wreg(2'd2, 8'h02);
        sigin[1] = 1'b0;
        to_cen(); tick();
        chk("fall_pend", {5'd0, pend0}, 8'h02);
        wreg(2'd1, 8'h02);
        rd_chk("pend_rd", 2'd1, 8'hF8);
        sigin[1] = 1'b1;
        to_cen(); tick();
        chk("rise_ign", {5'd0, pend0}, 8'h00);
        wreg(2'd2, 8'h00);
        to_cen(); tick();
        chk("polflip_stable", {5'd0, pend0}, 8'h00);

        // set beats clear: edge vs ack, force vs ack
        sigin[0] = 1'b1;
        to_cen();
        clr[0] = 1'b1;
        tick();
        chk("edge_vs_clr", {5'd0, pend0}, 8'h01);
        cs = 1'b1; wr = 1'b1; addr = 2'd3; din = 8'h04; clr[2] = 1'b1;
        tick();
        chk("force_vs_clr", {5'd0, pend0}, 8'h05);
        rd_chk("force_rd", 2'd3, 8'hF8);
        clr = 3'b101;
        tick();

        // sources held high through reset release: no edge
        sigin = 3'b111;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        to_cen(); tick();
        to_cen(); tick();
        chk("held_pend", {5'd0, pend0}, 8'h00);
        wreg(2'd3, 8'h07);
        chk("allf_pend", {5'd0, pend0}, 8'h07);
        chk("allf_irqn", {5'd0, irqn0}, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk("async_pend", {5'd0, pend0}, 8'h00);
        chk("async_irqn", {5'd0, irqn0}, 8'h07);
        chk("async_irqn_lvl", {5'd0, irqn1}, 8'h07);
        sigin = 3'b000;
        tick();
        rst = 1'b0;

        // level channel 0 on the second instance
        to_cen(); tick();
        sigin[0] = 1'b1;
        to_cen(); tick();
        chk("lvl_pend", {5'd0, pend1}, 8'h01);
        chk("lvl_irqn", {5'd0, irqn1}, 8'h06);
        clr[0] = 1'b1;
        tick();
        chk("lvl_clr_ign", {5'd0, pend1}, 8'h01);
        wreg(2'd1, 8'h01);
        chk("lvl_w1c_ign", {5'd0, pend1}, 8'h01);
        sigin[0] = 1'b0;
        to_cen(); tick();
        chk("lvl_low", {5'd0, pend1}, 8'h00);
        wreg(2'd3, 8'h01);
        chk("lvl_force", {5'd0, pend1}, 8'h01);
        to_cen(); tick();
        chk("lvl_force_end", {5'd0, pend1}, 8'h00);

        tick(); tick();
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtdd_irqctl.md
JTDD_IRQCTL -- requirements
Module: jtdd_irqctl

Interface
REQ-001 Parameter CH, default 3, number of interrupt channels, legal 1..8.
REQ-002 Parameter POL_RST, default 0 (CH bits), reset value of the polarity register (1 = falling edge).
REQ-003 Parameter MASK_RST, default all ones (CH bits), reset value of the enable mask.
REQ-004 Parameter LEVEL, default 0 (CH bits), per-channel level mode (1 = pending follows active level, no latch).
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 cen  input  1  sampling enable for interrupt sources.
REQ-008 sigin  input  CH  raw interrupt sources (e.g. VBL, IMS, MCU request).
REQ-009 clr  input  CH  per-channel acknowledge strobes, one clk wide, not cen-qualified.
REQ-010 cs  input  1  CPU register access select.
REQ-011 wr  input  1  write strobe, valid with cs, one clk wide.
REQ-012 addr  input  2  register select.
REQ-013 din  input  8  CPU write data.
REQ-014 dout  output  8  CPU read data, combinational from addr.
REQ-015 pend  output  CH  pending register.
REQ-016 irq_n  output  CH  active-low requests to the CPU.

Function
REQ-017 Register map: 0 mask (R/W); 1 pending (R; write 1 clears bit); 2 polarity (R/W); 3 force (W, 1 sets pending bit; reads 0).
REQ-018 Unused upper bits of dout read 1; bits at or above CH are ignored on write.
REQ-019 Sources sampled into sig_l only on clk edges with cen high; edge = sig_l differs from sample in the polarity direction.
REQ-020 Edge detected at cen cycle N sets pend bit at clk edge N; irq_n falls same edge (irq_n = ~(pend & mask), combinational from registers).
REQ-021 Edge-mode clear sources: clr bit, write-1 to addr 1; either clears pend at next clk edge.
REQ-022 Simultaneous set (edge or force) and clear on one channel in the same clk: set wins, bit stays 1.
REQ-023 Masked channel still latches pend; unmasking with pend=1 drives irq_n low immediately.
REQ-024 Level-mode channel: pend = sampled active level each cen; clr and write-1 ignored; force sets for one cen period only.
REQ-025 Polarity change while source stable shall not generate an edge (sig_l compared raw, polarity applied to transition direction only).
REQ-026 First cen after reset release only loads sig_l (armed flag); no edge detected that cycle.
REQ-027 Multiple edges before clear collapse into one pending bit; no counting.

Reset
REQ-028 On rst: pend=0, mask=MASK_RST, polarity=POL_RST, sig_l=0, armed=0; irq_n all 1 while rst high.
REQ-029 Reset asserted mid-pending drops the request asynchronously; no edge remembered across reset.

Structure
REQ-030 Register address constants (IRQ_MASK, IRQ_PEND, IRQ_POL, IRQ_FORCE) in shared package jtdd_pkg.
REQ-031 One sub-module jtdd_irqctl_ch instanced per channel (edge detect, pend latch); top holds register file and read mux.
REQ-032 Target 120-400 RTL lines; no clocks other than clk.

Verification
REQ-033 CH=3, reset, cen every 4 clk; sigin[2] 0->1 -> pend=3'b100, irq_n=3'b011 on that cen edge; clr[2] pulse -> irq_n=3'b111 next clk.
REQ-034 Write mask=8'h01, edge on ch1 -> pend=3'b010, irq_n=3'b111; write mask=8'h03 -> irq_n=3'b101 same cycle as register update.
REQ-035 Polarity=8'h02, sigin[1] 1->0 -> pend[1]=1; 0->1 -> no change; write 8'h02 to addr 1 -> pend=0; read addr 1 -> 8'hF8.
REQ-036 Edge on ch0 coincident with clr[0] -> pend[0] stays 1; force write 8'h04 with clr[2] -> pend[2]=1.
REQ-037 sigin=3'b111 held through reset release -> no pend bits after first two cen; assert rst with pend=3'b111 -> pend=0, irq_n=3'b111 asynchronously.
REQ-038 LEVEL=3'b001: sigin[0] high -> irq_n[0]=0; clr[0] ignored; sigin[0] low -> pend[0]=0 at next cen.
